enemies_wave_controller: RTL and testbench

ENEMIES_WAVE_CONTROLLER -- requirements
Module: enemies_wave_controller

---
 rtl/enemies_wave_controller.sv | 180 ++++++++++++++++++
 tb/tb_enemies_wave_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemies_wave_controller.sv
// Wave sequencer for four enemies: staggered spawns, hit/score tracking,
// inter-wave delay and per-wave speed ramp. All outputs are registered.
module enemies_wave_controller #(
    parameter int NUM_WAVES         = 8,
    parameter int SPAWN_GAP_FRAMES  = 20,
    parameter int WAVE_DELAY_FRAMES = 60,
    parameter int BASE_SPEED        = 120,
    parameter int SPEED_STEP        = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       gameStart,
    input  logic       pause,
    input  logic [3:0] enemyHit,
    output logic [3:0] enemyRespawnN,
    output logic [3:0] enemyAlive,
    output logic [3:0] waveNumber,
    output logic [7:0] enemySpeed,
    output logic [2:0] scoreAdd,
    output logic       waveDone,
    output logic       gameWon
);

    localparam int GAP_W = (SPAWN_GAP_FRAMES > 1) ? $clog2(SPAWN_GAP_FRAMES) : 1;
    localparam int DLY_W = (WAVE_DELAY_FRAMES > 1) ? $clog2(WAVE_DELAY_FRAMES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_CLEAR = 3'd3;
    localparam logic [2:0] S_WIN   = 3'd4;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [7:0] speed_of(input logic [3:0] w);
        return 8'(BASE_SPEED + int'(w) * SPEED_STEP);
    endfunction

    logic [2:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [3:0]       wave_q, wave_d;
    logic [3:0]       alive_q, alive_d;
    logic [3:0]       respawnN_q, respawnN_d;
    logic [7:0]       speed_q, speed_d;
    logic [2:0]       score_q, score_d;
    logic             done_q, done_d;
    logic             won_q, won_d;

    logic [3:0] hit_mask;
    logic [3:0] spawn_mask;
    logic       clr_alive;
    logic       frame_tick;

    assign frame_tick = startOfFrame & ~pause;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        dly_d      = dly_q;
        wave_d     = wave_q;
        won_d      = won_q;
        done_d     = 1'b0;
        speed_d    = speed_of(wave_q);
        hit_mask   = 4'b0000;
        spawn_mask = 4'b0000;
        clr_alive  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gameStart) begin
                    state_d = S_SPAWN;
                    wave_d  = 4'd0;
                    idx_d   = 2'd0;
                    gap_d   = '0;
                end
            end
            S_SPAWN: begin
                hit_mask = enemyHit & alive_q;
                if (frame_tick) begin
                    if (gap_q == '0) begin
                        spawn_mask = 4'b0001 << idx_q;
                        gap_d      = GAP_W'(SPAWN_GAP_FRAMES - 1);
                        idx_d      = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = S_PLAY;
                        end
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
            end
            S_PLAY: begin
                hit_mask = enemyHit & alive_q;
                if (alive_q == 4'b0000) begin
                    state_d = S_CLEAR;
                    done_d  = 1'b1;
                    dly_d   = DLY_W'(WAVE_DELAY_FRAMES - 1);
                end
            end
            S_CLEAR: begin
                if (frame_tick) begin
                    if (dly_q == '0) begin
                        if (wave_q == 4'(NUM_WAVES - 1)) begin
                            state_d = S_WIN;
                            won_d   = 1'b1;
                        end else begin
                            wave_d  = wave_q + 4'd1;
                            idx_d   = 2'd0;
                            gap_d   = '0;
                            state_d = S_SPAWN;
                        end
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end
            end
            S_WIN: begin
                won_d = 1'b1;
                if (gameStart) begin
                    won_d     = 1'b0;
                    wave_d    = 4'd0;
                    idx_d     = 2'd0;
                    gap_d     = '0;
                    clr_alive = 1'b1;
                    state_d   = S_SPAWN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A spawn overrides a hit on the same enemy in the same cycle: no kill, no score.
        hit_mask   = hit_mask & ~spawn_mask;
        alive_d    = clr_alive ? 4'b0000 : ((alive_q & ~hit_mask) | spawn_mask);
        respawnN_d = ~spawn_mask;
        score_d    = popcount4(hit_mask);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            gap_q      <= '0;
            dly_q      <= '0;
            wave_q     <= 4'd0;
            alive_q    <= 4'b0000;
            respawnN_q <= 4'b1111;
            speed_q    <= 8'(BASE_SPEED);
            score_q    <= 3'd0;
            done_q     <= 1'b0;
            won_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            dly_q      <= dly_d;
            wave_q     <= wave_d;
            alive_q    <= alive_d;
            respawnN_q <= respawnN_d;
            speed_q    <= speed_d;
            score_q    <= score_d;
            done_q     <= done_d;
            won_q      <= won_d;
        end
    end

    assign enemyRespawnN = respawnN_q;
    assign enemyAlive    = alive_q;
    assign waveNumber    = wave_q;
    assign enemySpeed    = speed_q;
    assign scoreAdd      = score_q;
    assign waveDone      = done_q;
    assign gameWon       = won_q;

endmodule

// File: tb/tb_enemies_wave_controller.sv
// Directed bench for enemies_wave_controller: spawn timing, hits, wave
// progression, pause, win/restart and asynchronous reset mid-play.
module tb_enemies_wave_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       gameStart;
    logic       pause;
    logic [3:0] enemyHit;
    logic [3:0] enemyRespawnN;
    logic [3:0] enemyAlive;
    logic [3:0] waveNumber;
    logic [7:0] enemySpeed;
    logic [2:0] scoreAdd;
    logic       waveDone;
    logic       gameWon;

    int checks = 0;
    int errors = 0;

    enemies_wave_controller #(
        .NUM_WAVES        (2),
        .SPAWN_GAP_FRAMES (20),
        .WAVE_DELAY_FRAMES(60),
        .BASE_SPEED       (120),
        .SPEED_STEP       (16)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .gameStart    (gameStart),
        .pause        (pause),
        .enemyHit     (enemyHit),
        .enemyRespawnN(enemyRespawnN),
        .enemyAlive   (enemyAlive),
        .waveNumber   (waveNumber),
        .enemySpeed   (enemySpeed),
        .scoreAdd     (scoreAdd),
        .waveDone     (waveDone),
        .gameWon      (gameWon)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        checks++; if (enemyRespawnN !== 4'b1111) begin errors++; $display("FAIL %s_respawnN got %b exp 1111", tag, enemyRespawnN); end
        checks++; if (enemyAlive !== 4'b0000) begin errors++; $display("FAIL %s_alive got %b exp 0000", tag, enemyAlive); end
        checks++; if (waveNumber !== 4'd0) begin errors++; $display("FAIL %s_wave got %0d exp 0", tag, waveNumber); end
        checks++; if (enemySpeed !== 8'd120) begin errors++; $display("FAIL %s_speed got %0d exp 120", tag, enemySpeed); end
        checks++; if (scoreAdd !== 3'd0) begin errors++; $display("FAIL %s_score got %0d exp 0", tag, scoreAdd); end
        checks++; if (waveDone !== 1'b0) begin errors++; $display("FAIL %s_waveDone got %b exp 0", tag, waveDone); end
        checks++; if (gameWon !== 1'b0) begin errors++; $display("FAIL %s_gameWon got %b exp 0", tag, gameWon); end
    endtask

    task automatic test_reset();
        resetN = 1'b1; startOfFrame = 1'b0; gameStart = 1'b0; pause = 1'b0; enemyHit = 4'b0000;
        #2 resetN = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_idle_ignores_frames_and_hits();
        for (int f = 0; f < 3; f++) begin
            enemyHit = 4'b1111; startOfFrame = 1'b1;
            tick();
            enemyHit = 4'b0000; startOfFrame = 1'b0;
            checks++; if (enemyRespawnN !== 4'b1111 || enemyAlive !== 4'b0000 || scoreAdd !== 3'd0) begin
                errors++; $display("FAIL idle_quiet got respawnN=%b alive=%b score=%0d exp 1111/0000/0", enemyRespawnN, enemyAlive, scoreAdd);
            end
            repeat (3) tick();
        end
    endtask

    // Runs one SPAWN phase of 61 frames; strobes expected at frames 1, 21, 41, 61.
    task automatic run_spawn(input bit with_hits, input string tag);
        logic [3:0] exp_alive;
        logic [3:0] spawnm;
        logic [3:0] hit;
        logic [3:0] killed;
        int         exp_score;
        exp_alive = 4'b0000;
        if (with_hits) begin
            for (int p = 0; p < 3; p++) begin
                pause = 1'b1; startOfFrame = 1'b1;
                tick();
                pause = 1'b0; startOfFrame = 1'b0;
                checks++; if (enemyRespawnN !== 4'b1111) begin errors++; $display("FAIL %s_paused_spawn got %b exp 1111", tag, enemyRespawnN); end
                repeat (3) tick();
            end
        end
        for (int f = 1; f <= 61; f++) begin
            hit = 4'b0000;
            if (with_hits && f == 21) hit = 4'b1010;
            if (with_hits && f == 30) hit = 4'b0001;
            case (f)
                1:       spawnm = 4'b0001;
                21:      spawnm = 4'b0010;
                41:      spawnm = 4'b0100;
                61:      spawnm = 4'b1000;
                default: spawnm = 4'b0000;
            endcase
            killed    = hit & exp_alive & ~spawnm;
            exp_alive = (exp_alive & ~killed) | spawnm;
            exp_score = $countones(killed);
            enemyHit = hit; startOfFrame = 1'b1;
            tick();
            enemyHit = 4'b0000; startOfFrame = 1'b0;
            checks++; if (enemyRespawnN !== ~spawnm) begin errors++; $display("FAIL %s_strobe_f%0d got %b exp %b", tag, f, enemyRespawnN, ~spawnm); end
            checks++; if (enemyAlive !== exp_alive) begin errors++; $display("FAIL %s_alive_f%0d got %b exp %b", tag, f, enemyAlive, exp_alive); end
            checks++; if (scoreAdd !== 3'(exp_score)) begin errors++; $display("FAIL %s_score_f%0d got %0d exp %0d", tag, f, scoreAdd, exp_score); end
            tick();
            checks++; if (enemyRespawnN !== 4'b1111 || scoreAdd !== 3'd0) begin
                errors++; $display("FAIL %s_pulse_len_f%0d got respawnN=%b score=%0d exp 1111/0", tag, f, enemyRespawnN, scoreAdd);
            end
            repeat (2) tick();
        end
    endtask

    task automatic test_spawn_timing();
        gameStart = 1'b1;
        tick();
        gameStart = 1'b0;
        run_spawn(1'b0, "w0");
    endtask

    task automatic test_simultaneous_hits();
        enemyHit = 4'b1011;
        tick();
        checks++; if (enemyAlive !== 4'b0100) begin errors++; $display("FAIL hits_alive got %b exp 0100", enemyAlive); end
        checks++; if (scoreAdd !== 3'd3) begin errors++; $display("FAIL hits_score got %0d exp 3", scoreAdd); end
        tick();
        checks++; if (scoreAdd !== 3'd0) begin errors++; $display("FAIL hits_repeat_score got %0d exp 0", scoreAdd); end
        enemyHit = 4'b0100;
        tick();
        checks++; if (enemyAlive !== 4'b0000 || scoreAdd !== 3'd1 || waveDone !== 1'b0) begin
            errors++; $display("FAIL hits_last got alive=%b score=%0d done=%b exp 0000/1/0", enemyAlive, scoreAdd, waveDone);
        end
        enemyHit = 4'b0000;
        tick();
        checks++; if (waveDone !== 1'b1) begin errors++; $display("FAIL wave0_done got %b exp 1", waveDone); end
        tick();
        checks++; if (waveDone !== 1'b0) begin errors++; $display("FAIL wave0_done_len got %b exp 0", waveDone); end
    endtask

    task automatic test_wave_progression();
        for (int f = 1; f <= 60; f++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            if (f == 59) begin
                checks++; if (waveNumber !== 4'd0) begin errors++; $display("FAIL clear_early_wave got %0d exp 0", waveNumber); end
            end
            if (f == 60) begin
                checks++; if (waveNumber !== 4'd1) begin errors++; $display("FAIL clear_wave got %0d exp 1", waveNumber); end
                checks++; if (enemySpeed !== 8'd120) begin errors++; $display("FAIL speed_lag got %0d exp 120", enemySpeed); end
            end
            tick();
            if (f == 60) begin
                checks++; if (enemySpeed !== 8'd136) begin errors++; $display("FAIL speed_w1 got %0d exp 136", enemySpeed); end
            end
            repeat (2) tick();
        end
        run_spawn(1'b1, "w1");
        enemyHit = 4'b1110;
        tick();
        enemyHit = 4'b0000;
        checks++; if (scoreAdd !== 3'd3 || enemyAlive !== 4'b0000) begin
            errors++; $display("FAIL w1_kill got score=%0d alive=%b exp 3/0000", scoreAdd, enemyAlive);
        end
        tick();
        checks++; if (waveDone !== 1'b1) begin errors++; $display("FAIL wave1_done got %b exp 1", waveDone); end
    endtask

    task automatic test_pause_clear();
        for (int f = 1; f <= 90; f++) begin
            pause = (f > 10 && f <= 40); startOfFrame = 1'b1;
            tick();
            pause = 1'b0; startOfFrame = 1'b0;
            if (f == 89) begin
                checks++; if (gameWon !== 1'b0) begin errors++; $display("FAIL pause_early_win got %b exp 0", gameWon); end
            end
            if (f == 90) begin
                checks++; if (gameWon !== 1'b1) begin errors++; $display("FAIL pause_win got %b exp 1", gameWon); end
            end
            repeat (3) tick();
        end
    endtask

    task automatic test_win_restart();
        repeat (5) tick();
        checks++; if (gameWon !== 1'b1) begin errors++; $display("FAIL win_held got %b exp 1", gameWon); end
        gameStart = 1'b1;
        tick();
        gameStart = 1'b0;
        checks++; if (gameWon !== 1'b0 || waveNumber !== 4'd0) begin
            errors++; $display("FAIL restart got won=%b wave=%0d exp 0/0", gameWon, waveNumber);
        end
        tick();
        checks++; if (enemySpeed !== 8'd120) begin errors++; $display("FAIL restart_speed got %0d exp 120", enemySpeed); end
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        checks++; if (enemyRespawnN !== 4'b1110) begin errors++; $display("FAIL restart_spawn0 got %b exp 1110", enemyRespawnN); end
        repeat (3) tick();
        gameStart = 1'b1;
        for (int f = 2; f <= 21; f++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            checks++; if (enemyRespawnN !== ((f == 21) ? 4'b1101 : 4'b1111)) begin
                errors++; $display("FAIL start_ignored_f%0d got %b exp %b", f, enemyRespawnN, (f == 21) ? 4'b1101 : 4'b1111);
            end
            repeat (3) tick();
        end
        gameStart = 1'b0;
    endtask

    task automatic test_reset_mid_play();
        for (int f = 22; f <= 61; f++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            repeat (3) tick();
        end
        checks++; if (enemyAlive !== 4'b1111) begin errors++; $display("FAIL play_alive got %b exp 1111", enemyAlive); end
        enemyHit = 4'b1001;
        tick();
        enemyHit = 4'b0000;
        checks++; if (enemyAlive !== 4'b0110 || scoreAdd !== 3'd2) begin
            errors++; $display("FAIL pre_reset got alive=%b score=%0d exp 0110/2", enemyAlive, scoreAdd);
        end
        #2 resetN = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) tick();
        checks++; if (waveDone !== 1'b0 || scoreAdd !== 3'd0) begin
            errors++; $display("FAIL midreset_hold got done=%b score=%0d exp 0/0", waveDone, scoreAdd);
        end
        resetN = 1'b1;
        tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        checks++; if (enemyRespawnN !== 4'b1111 || enemyAlive !== 4'b0000) begin
            errors++; $display("FAIL post_reset_idle got respawnN=%b alive=%b exp 1111/0000", enemyRespawnN, enemyAlive);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_ignores_frames_and_hits();
        test_spawn_timing();
        test_simultaneous_hits();
        test_wave_progression();
        test_pause_clear();
        test_win_restart();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
